// File: rtl/enc_dec_apb_rgf.sv
// APB slave register file: NUM_REGS config registers, a W1C STATUS register and an IRQ_EN mask,
// with a configurable number of wait states and a registered level interrupt.
module enc_dec_apb_rgf #(
    parameter int AMBA_ADDR_WIDTH = 32,
    parameter int AMBA_WORD       = 32,
    parameter int NUM_REGS        = 4,
    parameter int WAIT_STATES     = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0]    paddr,
    input  logic [AMBA_WORD-1:0]          pwdata,
    input  logic [AMBA_WORD/8-1:0]        pstrb,
    output logic [AMBA_WORD-1:0]          prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [NUM_REGS*AMBA_WORD-1:0] reg_out,
    input  logic [AMBA_WORD-1:0]          status_in,
    input  logic                          status_vld,
    output logic                          irq
);

    localparam int IDXW = AMBA_ADDR_WIDTH - 2;
    localparam int NB   = AMBA_WORD / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state;
    logic [1:0]           count;
    logic [AMBA_WORD-1:0] cfg [NUM_REGS];
    logic [AMBA_WORD-1:0] status;
    logic [AMBA_WORD-1:0] irq_en;

    logic [IDXW-1:0]      idx;
    logic                 addr_ok;
    logic                 last_wait;
    logic                 wr_en;
    logic [AMBA_WORD-1:0] byte_mask;
    logic [AMBA_WORD-1:0] rd_data;
    logic [AMBA_WORD-1:0] status_set;
    logic [AMBA_WORD-1:0] status_clr;

    always_comb begin
        idx       = paddr[AMBA_ADDR_WIDTH-1:2];
        addr_ok   = (paddr[1:0] == 2'b00) && (idx <= IDXW'(NUM_REGS + 1));
        last_wait = ({1'b0, count} + 3'd1) == 3'(WAIT_STATES);
        wr_en     = (state == ACCESS) && pready && pwrite && addr_ok;
        byte_mask = '0;
        for (int b = 0; b < NB; b++) begin
            byte_mask[b*8 +: 8] = {8{pstrb[b]}};
        end
        rd_data = '0;
        if (addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IDXW'(i)) rd_data = cfg[i];
            end
            if (idx == IDXW'(NUM_REGS))     rd_data = status;
            if (idx == IDXW'(NUM_REGS + 1)) rd_data = irq_en;
        end
        // A new event outranks a software clear of the same bit.
        status_set = status_vld ? status_in : '0;
        status_clr = (wr_en && idx == IDXW'(NUM_REGS)) ? (pwdata & byte_mask) : '0;
    end

    // pready/pslverr are precomputed one cycle ahead so they are high exactly in the completion cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            count   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count   <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (psel && !penable) state <= SETUP;
                end
                SETUP: begin
                    state   <= ACCESS;
                    count   <= '0;
                    pready  <= (WAIT_STATES == 0);
                    pslverr <= (WAIT_STATES == 0) && !addr_ok;
                    if (!pwrite) prdata <= rd_data;
                end
                ACCESS: begin
                    if (pready || !psel) begin
                        state   <= IDLE;
                        count   <= '0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else begin
                        count   <= count + 2'd1;
                        pready  <= last_wait;
                        pslverr <= last_wait && !addr_ok;
                    end
                end
                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) cfg[i] <= '0;
            status <= '0;
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && idx == IDXW'(i)) cfg[i] <= (cfg[i] & ~byte_mask) | (pwdata & byte_mask);
            end
            if (wr_en && idx == IDXW'(NUM_REGS + 1)) begin
                irq_en <= (irq_en & ~byte_mask) | (pwdata & byte_mask);
            end
            status <= (status & ~status_clr) | status_set;
            irq    <= |(status & irq_en);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*AMBA_WORD +: AMBA_WORD] = cfg[g];
    end

endmodule

// File: tb/tb_enc_dec_apb_rgf.sv
// Scoreboard bench for enc_dec_apb_rgf: three instances with 0, 2 and 3 wait states share one APB bus
// (separate psel); expected responses are queued by the driver and checked by a pready monitor.
module tb_enc_dec_apb_rgf;

    logic              clk = 1'b0;
    logic              rstn;
    logic [2:0]        psel_v;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       status_in;
    logic              status_vld;
    logic [2:0][31:0]  prdata_o;
    logic [2:0]        pready_o;
    logic [2:0]        pslverr_o;
    logic [2:0]        irq_o;
    logic [2:0][127:0] reg_out_o;

    typedef struct {
        int          dut;
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        enc_dec_apb_rgf #(
            .AMBA_ADDR_WIDTH(32),
            .AMBA_WORD(32),
            .NUM_REGS(4),
            .WAIT_STATES(g == 0 ? 0 : g + 1)
        ) dut (
            .clk(clk),
            .rstn(rstn),
            .psel(psel_v[g]),
            .penable(penable),
            .pwrite(pwrite),
            .paddr(paddr),
            .pwdata(pwdata),
            .pstrb(pstrb),
            .prdata(prdata_o[g]),
            .pready(pready_o[g]),
            .pslverr(pslverr_o[g]),
            .reg_out(reg_out_o[g]),
            .status_in(status_in),
            .status_vld(status_vld),
            .irq(irq_o[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Every pready must match the oldest queued expectation; a pready with nothing queued is an error.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pready_o[d] !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    checkOutput($sformatf("spurious pready dut%0d", d), 32'(pready_o[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("responding dut", d, e.dut);
                    checkOutput($sformatf("pslverr dut%0d", d), 32'(pslverr_o[d]), 32'(e.err));
                    if (e.rd) checkOutput($sformatf("prdata dut%0d", d), prdata_o[d], e.data);
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [31:0] exp_rd, input logic exp_err, input logic set_vld);
        exp_t e;
        int   lat;
        int   ws;
        logic done;
        ws    = (d == 0) ? 0 : d + 1;
        e.dut = d;
        e.rd  = !wr;
        e.data = exp_rd;
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        psel_v = '0;
        psel_v[d] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = data;
        pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
            if (pready_o[d] === 1'b1) done = 1'b1;
        end
        if (set_vld) begin
            status_in = 32'h1;
            status_vld = 1'b1;
        end
        @(posedge clk); #1;
        psel_v = '0;
        penable = 1'b0;
        status_vld = 1'b0;
        status_in = '0;
        checkOutput($sformatf("latency dut%0d addr %h", d, addr), lat, ws + 2);
    endtask

    task automatic pulseStatus(input logic [31:0] bits);
        @(posedge clk); #1;
        status_in = bits;
        status_vld = 1'b1;
        @(posedge clk); #1;
        status_in = '0;
        status_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        rstn = 1'b0;
        psel_v = '0;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = '0;
        pwdata = '0;
        pstrb = '0;
        status_in = '1;
        status_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        status_vld = 1'b0;
        status_in = '0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 4; r++) begin
                checkOutput($sformatf("reset reg_out dut%0d r%0d", d, r), reg_out_o[d][r*32 +: 32], 32'h0);
            end
            checkOutput($sformatf("reset prdata dut%0d", d), prdata_o[d], 32'h0);
            checkOutput($sformatf("reset pready dut%0d", d), 32'(pready_o[d]), 32'h0);
            checkOutput($sformatf("reset pslverr dut%0d", d), 32'(pslverr_o[d]), 32'h0);
            checkOutput($sformatf("reset irq dut%0d", d), 32'(irq_o[d]), 32'h0);
        end
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);

        applyStimulus(0, 1'b1, 32'h04, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("dut0 reg1 after write", reg_out_o[0][63:32], 32'hA5A5_1234);
        checkOutput("dut0 reg0 untouched", reg_out_o[0][31:0], 32'h0);
        applyStimulus(0, 1'b0, 32'h04, 32'h0, 4'hF, 32'hA5A5_1234, 1'b0, 1'b0);

        @(posedge clk); #1;
        psel_v = 3'b001;
        penable = 1'b1;
        pwrite = 1'b1;
        paddr = 32'h0;
        pwdata = 32'hDEAD_BEEF;
        pstrb = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        psel_v = '0;
        penable = 1'b0;
        @(negedge clk);
        checkOutput("dut0 reg0 after ignored access", reg_out_o[0][31:0], 32'h0);

        applyStimulus(1, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'h3, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("dut1 reg0 strobed write", reg_out_o[1][31:0], 32'h0000_FFFF);
        applyStimulus(1, 1'b0, 32'h00, 32'h0, 4'hF, 32'h0000_FFFF, 1'b0, 1'b0);

        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 32'h02, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("dut0 reg0 after bad write", reg_out_o[0][31:0], 32'h0);
        checkOutput("dut0 reg1 after bad write", reg_out_o[0][63:32], 32'hA5A5_1234);

        applyStimulus(0, 1'b1, 32'h14, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 32'h14, 32'h0, 4'hF, 32'h1, 1'b0, 1'b0);
        pulseStatus(32'h1);
        @(negedge clk);
        checkOutput("irq right after status set", 32'(irq_o[0]), 32'h0);
        @(negedge clk);
        checkOutput("irq one cycle after status set", 32'(irq_o[0]), 32'h1);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1, 1'b0, 1'b0);

        applyStimulus(0, 1'b1, 32'h10, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("irq right after W1C", 32'(irq_o[0]), 32'h1);
        @(negedge clk);
        checkOutput("irq one cycle after W1C", 32'(irq_o[0]), 32'h0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);

        pulseStatus(32'h1);
        applyStimulus(0, 1'b1, 32'h10, 32'h1, 4'hF, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h1, 1'b0, 1'b0);
        checkOutput("irq after set/clear collision", 32'(irq_o[0]), 32'h1);

        applyStimulus(2, 1'b1, 32'h04, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        psel_v = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h04;
        pwdata = 32'h2222_2222;
        pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_v = '0;
        penable = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (pready_o[2] !== 1'b0) cnt++;
        end
        checkOutput("pready count after abort", cnt, 0);
        checkOutput("dut2 reg1 after abort", reg_out_o[2][63:32], 32'h1111_1111);
        applyStimulus(2, 1'b0, 32'h04, 32'h0, 4'hF, 32'h1111_1111, 1'b0, 1'b0);

        @(posedge clk); #1;
        psel_v = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h00;
        pwdata = 32'h3333_3333;
        @(posedge clk); #1;
        penable = 1'b1;
        rstn = 1'b0;
        @(posedge clk); #1;
        psel_v = '0;
        penable = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("dut2 prdata after reset in SETUP", prdata_o[2], 32'h0);
        checkOutput("dut2 reg0 after reset in SETUP", reg_out_o[2][31:0], 32'h0);
        checkOutput("dut2 reg1 after reset in SETUP", reg_out_o[2][63:32], 32'h0);
        checkOutput("dut2 pslverr after reset", 32'(pslverr_o[2]), 32'h0);
        checkOutput("dut0 irq after reset", 32'(irq_o[0]), 32'h0);
        repeat (4) @(negedge clk);
        applyStimulus(2, 1'b0, 32'h00, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
        checkOutput("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
